exp_result_receiver: RTL and testbench

// - Downstream receiver for the pipelined Q7.25 exponential evaluator. Accepts
//   32-bit results on a valid/ready stream and drives that pipeline's i_ready.
// - Buffers results in a DEPTH-entry FIFO and serialises each word onto a 16-bit

---
 rtl/exp_result_receiver.sv | 163 ++++++++++++++++
 tb/tb_exp_result_receiver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_result_receiver.sv
// exp_result_receiver: downstream sink for the pipelined Q7.25 exponential
// evaluator. Buffers 32-bit results in a small FIFO and replays each one as
// two 16-bit beats (low half, then high half) on a valid/ready stream.
module exp_result_receiver #(
    parameter int WIDTHIN  = 32,
    parameter int WIDTHOUT = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [WIDTHIN-1:0]  in_data,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTHOUT-1:0] out_data,
    output logic                out_last,
    output logic [15:0]         rx_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI
    } state_t;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTHIN-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic [15:0]        rx_count_q, rx_count_d;
    state_t             state_q, state_d;

    logic               push;
    logic               pop;
    logic [WIDTHIN-1:0] head;

    // Handshake qualifiers: a push needs the registered ready, a pop is the
    // acceptance of the upper-half beat.
    assign push = in_valid && in_ready_q;
    assign pop  = (state_q == ST_HI) && out_ready;
    assign head = mem_q[rd_ptr_q];

    assign in_ready = in_ready_q;
    assign rx_count = rx_count_q;

    // NOTE: the storage array is deliberately left out of reset; the
    // pointers and occupancy counter make stale entries unreachable.
    // Storage write at the tail on every accepted input word.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Next-state for pointers, occupancy, registered ready and result count.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rx_count_d = rx_count_q;

        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
            rx_count_d = rx_count_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Ready is a pure function of the next occupancy, so there is no
        // combinational path from in_valid or out_ready to in_ready.
        in_ready_d = (count_d < FULL_CNT);
    end

    // Datapath registers; reset empties the FIFO and holds in_ready low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples its pre-edge inputs regardless of statement order.
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            rx_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            rx_count_q <= rx_count_d;
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM next-state: LO then HI per word, chaining straight into the
    // next word's LO beat when the FIFO still holds one after the pop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (out_ready) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (out_ready) begin
                    state_d = (count_d != '0) ? ST_LO : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output FSM outputs: beats come straight from the head entry, zero in IDLE.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        unique case (state_q)
            ST_LO: begin
                out_valid = 1'b1;
                out_data  = head[WIDTHOUT-1:0];
            end
            ST_HI: begin
                out_valid = 1'b1;
                out_data  = head[WIDTHIN-1:WIDTHOUT];
                out_last  = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_exp_result_receiver.sv
// Self-checking bench for exp_result_receiver: a transaction-level scoreboard
// (queue of expected beats, word occupancy, result count) checks every cycle,
// plus a directed vector table and hand-written multi-cycle sequences.
module tb_exp_result_receiver;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic [15:0] rx_count;

    exp_result_receiver #(
        .WIDTHIN (32),
        .WIDTHOUT(16),
        .DEPTH   (DEPTH),
        .AW      (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .rx_count (rx_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [15:0] e_od;
        logic        e_ol;
        logic [15:0] e_rx;
    } vec_t;

    // Reference model: expected beats in order, words held, results counted.
    beat_t       exp_beats[$];
    int          occ;
    logic [15:0] exp_rx;

    int n_checks = 0;
    int n_errors = 0;
    bit acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: record handshakes seen before the edge, advance the
    // model, then check the post-edge outputs against it.
    task automatic step(output bit accepted);
        bit          acc_in;
        bit          acc_out;
        bit          pre_v;
        bit          pre_l;
        bit          pre_rdy;
        logic [15:0] pre_d;
        beat_t       eb;
        acc_in  = in_valid && in_ready;
        acc_out = out_valid && out_ready;
        pre_v   = out_valid;
        pre_l   = out_last;
        pre_d   = out_data;
        pre_rdy = out_ready;
        if (acc_out) begin
            check("beat_expected", exp_beats.size() != 0, 1);
            if (exp_beats.size() != 0) begin
                eb = exp_beats.pop_front();
                check("beat_data", out_data, eb.data);
                check("beat_last", out_last, eb.last);
                if (eb.last) occ--;
            end
        end
        if (acc_in) begin
            exp_beats.push_back('{in_data[15:0], 1'b0});
            exp_beats.push_back('{in_data[31:16], 1'b1});
            occ++;
            exp_rx++;
        end
        @(posedge clk);
        #1;
        check("in_ready", in_ready, occ < DEPTH);
        check("rx_count", rx_count, exp_rx);
        if (pre_v && !pre_rdy) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, pre_d);
            check("hold_last", out_last, pre_l);
        end
        if (!out_valid) begin
            check("idle_data", out_data, 0);
            check("idle_last", out_last, 0);
        end
        accepted = acc_in;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_rx_count", rx_count, 0);
        exp_beats.delete();
        occ    = 0;
        exp_rx = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        check("rel_ready_low", in_ready, 0);
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < budget && exp_beats.size() != 0; n++) begin
            step(acc);
        end
        check("drain_done", exp_beats.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 32'h0570_0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd1};
        vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'd1};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 16'h0570, 1'b1, 16'd1};
        vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd1};
        vecs[5] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd1};

        do_reset();

        // Single word e^1 through the vector table.
        for (int i = 0; i < 6; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            step(acc);
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_irdy);
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
            check($sformatf("vec%0d_out_last", i), out_last, vecs[i].e_ol);
            check($sformatf("vec%0d_rx_count", i), rx_count, vecs[i].e_rx);
        end

        // Fill with sink stalled: 8 accepted, 9th held off.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            step(acc);
            check("fill_accept", acc, 1);
        end
        check("fill_full_ready", in_ready, 0);
        check("fill_rx", rx_count, 16'd9);
        in_data = 32'h9;
        for (int i = 0; i < 4; i++) begin
            step(acc);
            check("full_block", acc, 0);
        end
        out_ready = 1'b1;
        for (int n = 0; n < 60 && (exp_beats.size() != 0 || in_valid); n++) begin
            if (exp_beats.size() != 0) check("stream_no_gap", out_valid, 1);
            step(acc);
            if (acc) in_valid = 1'b0;
        end
        check("word9_accepted", in_valid, 0);
        check("fill_drained", exp_beats.size(), 0);
        check("fill_rx_final", rx_count, 16'd10);

        // Sink stalls for three cycles on the upper-half beat.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA_1111;
        step(acc);
        in_data = 32'hBBBB_2222;
        step(acc);
        in_valid = 1'b0;
        check("stall_lo_valid", out_valid, 1);
        check("stall_lo_data", out_data, 16'h1111);
        out_ready = 1'b1;
        step(acc);
        check("stall_hi_data", out_data, 16'hAAAA);
        check("stall_hi_last", out_last, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(acc);
            check("stall_hold_data", out_data, 16'hAAAA);
            check("stall_hold_last", out_last, 1);
        end
        out_ready = 1'b1;
        step(acc);
        check("stall_next_data", out_data, 16'h2222);
        check("stall_next_last", out_last, 0);
        drain(20);

        // Fill to full, free one slot, then push in the same cycle as a pop.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC000_0000 + 32'(i);
            step(acc);
        end
        in_valid = 1'b0;
        check("full_ready_low", in_ready, 0);
        out_ready = 1'b1;
        for (int n = 0; n < 10 && !(out_valid && out_last && in_ready); n++) begin
            step(acc);
        end
        check("simul_setup", out_valid && out_last && in_ready, 1);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step(acc);
        in_valid = 1'b0;
        check("simul_push", acc, 1);
        check("simul_ready", in_ready, 1);
        check("simul_next_valid", out_valid, 1);
        check("simul_next_last", out_last, 0);
        drain(60);

        // Randomised traffic: a congested phase, then a free-flowing one.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < ((c < 750) ? 35 : 75));
            step(acc);
        end
        drain(100);

        // Reset with 5 words buffered and the FSM on an upper-half beat.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h5000_0000 + 32'(i);
            step(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(acc);
        check("midrst_in_hi", out_last, 1);
        do_reset();
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        out_ready = 1'b1;
        acc       = 1'b0;
        for (int n = 0; n < 5 && !acc; n++) begin
            step(acc);
        end
        in_valid = 1'b0;
        check("post_rst_accept", acc, 1);
        check("post_rst_rx", rx_count, 16'd1);
        drain(20);
        check("post_rst_idle", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
